// File: rtl/inst_queue_if.sv
// Fetch/decode handshake bundle for inst_queue.
// slave  : the queue side (consumes fetch offers, drives decode head).
// master : the environment side (fetch stage and decode control).
interface inst_queue_if #(
    parameter int DEPTH    = 4,
    parameter int INSN_LEN = 32,
    parameter int ADDR_LEN = 32
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    // fetch side
    logic                fetch_valid_i;
    logic [INSN_LEN-1:0] fetch_inst_i;
    logic [ADDR_LEN-1:0] fetch_pc_i;
    logic                fetch_ready_o;

    // decode side
    logic [INSN_LEN-1:0] inst1_o;
    logic [ADDR_LEN-1:0] pc1_o;
    logic                inv1_o;
    logic                stall_DP_i;
    logic                kill_ID_i;

    // occupancy
    logic [CNT_W-1:0]    count_o;

    modport slave (
        input  fetch_valid_i,
        input  fetch_inst_i,
        input  fetch_pc_i,
        output fetch_ready_o,
        output inst1_o,
        output pc1_o,
        output inv1_o,
        input  stall_DP_i,
        input  kill_ID_i,
        output count_o
    );

    modport master (
        output fetch_valid_i,
        output fetch_inst_i,
        output fetch_pc_i,
        input  fetch_ready_o,
        input  inst1_o,
        input  pc1_o,
        input  inv1_o,
        output stall_DP_i,
        output kill_ID_i,
        input  count_o
    );
endinterface

// File: rtl/inst_queue.sv
// Instruction queue between fetch and decode.
// Circular buffer of DEPTH {inst, pc} entries; the oldest entry is presented
// combinationally to the decode latch, with inv1_o flagging "no instruction"
// (NOP, pc 0). kill_ID_i flushes everything and blocks the offer that cycle.
// Optional macro IQ_BYPASS_EN: when the queue is empty, a fetch offer is shown
// on the decode outputs in the same cycle and, if the decoder takes it, it is
// never written into storage.
module inst_queue #(
    parameter int DEPTH    = 4,
    parameter int INSN_LEN = 32,
    parameter int ADDR_LEN = 32
) (
    input logic          clk_i,
    input logic          reset_i,
    inst_queue_if.slave  iq
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    localparam logic [INSN_LEN-1:0] NOP_INSN   = INSN_LEN'(32'h0000_0013);
    localparam logic [CNT_W-1:0]    FULL_COUNT = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0]    PTR_ONE    = PTR_W'(1);
    localparam logic [CNT_W-1:0]    CNT_ONE    = CNT_W'(1);

    // storage (not reset; validity is tracked by count)
    logic [INSN_LEN-1:0] inst_mem [DEPTH];
    logic [ADDR_LEN-1:0] pc_mem   [DEPTH];

    // pointers and occupancy
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] count;
    logic [PTR_W-1:0] head_next;
    logic [PTR_W-1:0] tail_next;
    logic [CNT_W-1:0] count_next;

    // handshake terms
    logic full;
    logic empty;
    logic ready;
    logic push;
    logic pop;
    logic mem_write;
    logic mem_read;

    // head presentation
    logic [INSN_LEN-1:0] head_inst;
    logic [ADDR_LEN-1:0] head_pc;
    logic                head_inv;

    assign full  = (count == FULL_COUNT);
    assign empty = (count == '0);

    // Readiness depends only on registered occupancy and kill, never on stall,
    // so the fetch stage sees no combinational path from dispatch.
    assign ready = reset_i & ~full & ~iq.kill_ID_i;
    assign push  = iq.fetch_valid_i & ready;

`ifdef IQ_BYPASS_EN
    logic bypass_hit;

    // An offer may be shown directly only when nothing older is waiting.
    assign bypass_hit = reset_i & empty & iq.fetch_valid_i & ~iq.kill_ID_i;
`endif

    // Select what the decoder sees: head entry, bypassed offer, or a NOP.
    always_comb begin
        head_inst = NOP_INSN;
        head_pc   = '0;
        head_inv  = 1'b1;
        if (!empty) begin
            head_inst = inst_mem[head];
            head_pc   = pc_mem[head];
            head_inv  = 1'b0;
        end
`ifdef IQ_BYPASS_EN
        else if (bypass_hit) begin
            head_inst = iq.fetch_inst_i;
            head_pc   = iq.fetch_pc_i;
            head_inv  = 1'b0;
        end
`endif
    end

    // The decoder consumes whatever valid head it sees unless stalled or killed.
    assign pop = ~head_inv & ~iq.stall_DP_i & ~iq.kill_ID_i;

    // A bypassed instruction that is consumed immediately never touches storage.
`ifdef IQ_BYPASS_EN
    assign mem_write = push & ~(bypass_hit & pop);
`else
    assign mem_write = push;
`endif
    assign mem_read = pop & ~empty;

    // Next pointer/occupancy values; a kill resets everything and wins over push/pop.
    always_comb begin
        head_next  = head;
        tail_next  = tail;
        count_next = count;
        if (iq.kill_ID_i) begin
            head_next  = '0;
            tail_next  = '0;
            count_next = '0;
        end else begin
            if (mem_write) begin
                tail_next = tail + PTR_ONE;
            end
            if (mem_read) begin
                head_next = head + PTR_ONE;
            end
            case ({mem_write, mem_read})
                2'b10:   count_next = count + CNT_ONE;
                2'b01:   count_next = count - CNT_ONE;
                default: count_next = count;
            endcase
        end
    end

    // Pointer and occupancy registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head_next;
            tail  <= tail_next;
            count <= count_next;
        end
    end

    // Write the accepted instruction into the slot at the tail.
    always_ff @(posedge clk_i) begin
        if (mem_write) begin
            inst_mem[tail] <= iq.fetch_inst_i;
            pc_mem[tail]   <= iq.fetch_pc_i;
        end
    end

    assign iq.fetch_ready_o = ready;
    assign iq.inst1_o       = head_inst;
    assign iq.pc1_o         = head_pc;
    assign iq.inv1_o        = head_inv;
    assign iq.count_o       = count;

    // Occupancy can never exceed the number of slots.
    a_count_bound: assert property (@(posedge clk_i) disable iff (!reset_i)
        count <= FULL_COUNT);

    // Tail always sits count slots after the head (modulo DEPTH).
    a_ptr_consistent: assert property (@(posedge clk_i) disable iff (!reset_i)
        tail == head + PTR_W'(count));

    // A kill leaves the queue empty on the following cycle.
    a_kill_empties: assert property (@(posedge clk_i) disable iff (!reset_i)
        iq.kill_ID_i |=> (count == '0));

    // A stalled, valid head is not consumed and stays put.
    a_stall_holds: assert property (@(posedge clk_i) disable iff (!reset_i)
        (iq.stall_DP_i && !iq.kill_ID_i && !empty) |=> $stable(head));
endmodule

// File: tb/tb_inst_queue.sv
// Self-checking bench for inst_queue (scoreboard style).
// The stimulus process keeps a small occupancy model and pushes every accepted
// instruction onto exp_q; an independent monitor pops exp_q whenever the DUT
// hands a valid head to the decoder and compares it. Honours IQ_BYPASS_EN.
module tb_inst_queue;
    localparam int DEPTH    = 4;
    localparam int INSN_LEN = 32;
    localparam int ADDR_LEN = 32;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;

    int tests_run    = 0;
    int tests_failed = 0;
    int model_count  = 0;

    logic [63:0] exp_q[$];

    inst_queue_if #(.DEPTH(DEPTH), .INSN_LEN(INSN_LEN), .ADDR_LEN(ADDR_LEN)) bus ();

    inst_queue #(.DEPTH(DEPTH), .INSN_LEN(INSN_LEN), .ADDR_LEN(ADDR_LEN)) dut (
        .clk_i   (clk),
        .reset_i (reset_n),
        .iq      (bus)
    );

    // Free-running clock, 10 time-unit period.
    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [63:0] actual,
                                input logic [63:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Monitor: whenever the decoder takes a valid head, it must be the oldest expected entry.
    always @(negedge clk) begin
        logic [63:0] want;
        if (reset_n && !bus.inv1_o && !bus.stall_DP_i && !bus.kill_ID_i) begin
            if (exp_q.size() == 0) begin
                tests_run++;
                tests_failed++;
                $display("[TB] FAIL consume: got %h/%h, expected no instruction",
                         bus.inst1_o, bus.pc1_o);
            end else begin
                want = exp_q.pop_front();
                check_output("consume", {bus.inst1_o, bus.pc1_o}, want);
            end
        end
    end

    // Drive one cycle (called at posedge+1), check combinational outputs, step the model.
    task automatic apply_stimulus(input logic valid, input logic [31:0] inst,
                                  input logic [31:0] pc, input logic stall,
                                  input logic kill);
        logic ready_exp, push_exp, pop_exp, inv_exp, bypass_exp;
        int   next_count;
        bus.fetch_valid_i = valid;
        bus.fetch_inst_i  = inst;
        bus.fetch_pc_i    = pc;
        bus.stall_DP_i    = stall;
        bus.kill_ID_i     = kill;

        ready_exp = !kill && (model_count < DEPTH);
        push_exp  = valid && ready_exp;
`ifdef IQ_BYPASS_EN
        bypass_exp = (model_count == 0) && valid && !kill;
`else
        bypass_exp = 1'b0;
`endif
        inv_exp = (model_count == 0) && !bypass_exp;
        pop_exp = !inv_exp && !stall && !kill;

        if (kill) begin
            exp_q.delete();
            next_count = 0;
        end else begin
            if (push_exp) exp_q.push_back({inst, pc});
            next_count = model_count;
            if (push_exp && !(bypass_exp && pop_exp)) next_count++;
            if (pop_exp && model_count > 0) next_count--;
        end

        #2;
        check_output("fetch_ready", 64'(bus.fetch_ready_o), 64'(ready_exp));
        check_output("count", 64'(bus.count_o), 64'(model_count));
        check_output("inv1", 64'(bus.inv1_o), 64'(inv_exp));
        if (inv_exp) begin
            check_output("nop_inst", 64'(bus.inst1_o), 64'(NOP));
            check_output("nop_pc", 64'(bus.pc1_o), 64'd0);
        end else if (exp_q.size() > 0) begin
            check_output("head", {bus.inst1_o, bus.pc1_o}, exp_q[0]);
        end

        @(posedge clk);
        model_count = next_count;
        #1;
    endtask

    task automatic idle(input logic stall);
        apply_stimulus(1'b0, 32'h0, 32'h0, stall, 1'b0);
    endtask

    // One-cycle synchronous reset pulse while the queue may hold entries.
    task automatic do_reset();
        reset_n           = 1'b0;
        bus.fetch_valid_i = 1'b0;
        bus.stall_DP_i    = 1'b1;
        bus.kill_ID_i     = 1'b0;
        #2;
        check_output("ready_in_reset", 64'(bus.fetch_ready_o), 64'd0);
        @(posedge clk);
        exp_q.delete();
        model_count = 0;
        #1;
        reset_n = 1'b1;
    endtask

    // Safety net against a hung run.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bus.fetch_valid_i = 1'b0;
        bus.fetch_inst_i  = '0;
        bus.fetch_pc_i    = '0;
        bus.stall_DP_i    = 1'b0;
        bus.kill_ID_i     = 1'b0;
        reset_n           = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;

        // reset state, idle
        idle(1'b0);

        // single instruction through an empty queue
        apply_stimulus(1'b1, 32'h0050_0093, 32'h0000_0100, 1'b0, 1'b0);
        idle(1'b0);
        idle(1'b0);

        // fill under stall; the fifth offer must be refused
        for (int i = 0; i < 5; i++)
            apply_stimulus(1'b1, 32'h0010_0113 + 32'(i << 20), 32'h200 + 32'(4 * i), 1'b1, 1'b0);
        idle(1'b1);
        // release stall: drain in order with wrapping pointers
        for (int i = 0; i < 5; i++) idle(1'b0);

        // simultaneous push and pop at count 2
        apply_stimulus(1'b1, 32'h0000_0a13, 32'h300, 1'b1, 1'b0);
        apply_stimulus(1'b1, 32'h0000_0b13, 32'h304, 1'b1, 1'b0);
        apply_stimulus(1'b1, 32'h0000_0c13, 32'h308, 1'b0, 1'b0);
        apply_stimulus(1'b1, 32'h0000_0d13, 32'h30c, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) idle(1'b0);

        // kill at count 3 with an offer present
        for (int i = 0; i < 3; i++)
            apply_stimulus(1'b1, 32'h0040_0213 + 32'(i), 32'h400 + 32'(4 * i), 1'b1, 1'b0);
        apply_stimulus(1'b1, 32'hdead_0013, 32'h4ff, 1'b1, 1'b1);
        apply_stimulus(1'b1, 32'h0050_0313, 32'h500, 1'b0, 1'b0);
        idle(1'b0);
        idle(1'b0);

        // reset with three entries held, then normal traffic
        for (int i = 0; i < 3; i++)
            apply_stimulus(1'b1, 32'h0060_0413 + 32'(i), 32'h600 + 32'(4 * i), 1'b1, 1'b0);
        do_reset();
        idle(1'b0);
        apply_stimulus(1'b1, 32'h0070_0513, 32'h700, 1'b0, 1'b0);
        idle(1'b0);

        // bounded drain, then everything issued must have been consumed
        for (int i = 0; i < 8; i++) begin
            if (exp_q.size() == 0 && model_count == 0) break;
            idle(1'b0);
        end
        check_output("drain_empty", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
